// File: rtl/aes_pkg.sv
// Shared AES controller definitions: round counts, FSM encoding, block type, Rcon lookup.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package aes_pkg;

    localparam int BLK_W  = 128;
    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    // Bit 0 is the MSB of byte 0, so a 128'h literal reads byte 0 first.
    typedef logic [0:BLK_W-1] blk_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } ctrl_state_e;

    // Round constant for round r (1-based); zero for anything outside 1..10.
    function automatic logic [7:0] rcon_of(input int unsigned r);
        case (r)
            1:       rcon_of = 8'h01;
            2:       rcon_of = 8'h02;
            3:       rcon_of = 8'h04;
            4:       rcon_of = 8'h08;
            5:       rcon_of = 8'h10;
            6:       rcon_of = 8'h20;
            7:       rcon_of = 8'h40;
            8:       rcon_of = 8'h80;
            9:       rcon_of = 8'h1b;
            10:      rcon_of = 8'h36;
            default: rcon_of = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block-level handshake bundle: plaintext/key in (valid/ready), ciphertext out (valid/ready).
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready carry it; master = producer/consumer side, slave = controller.
interface aes_round_ctrl_if;
    import aes_pkg::*;

    logic in_valid;
    logic in_ready;
    blk_t in_pt;
    blk_t in_key;
    logic out_valid;
    logic out_ready;
    blk_t out_ct;

    modport master (
        output in_valid, in_pt, in_key, out_ready,
        input  in_ready, out_valid, out_ct
    );

    modport slave (
        input  in_valid, in_pt, in_key, out_ready,
        output in_ready, out_valid, out_ct
    );

endinterface

// File: rtl/aes_rcon_rom.sv
// Round-number to Rcon byte lookup, purely combinational.
// Latency: 0 cycles.
// Backpressure: none.
// Ports: rnd_num (round index), rcon (byte; 0x00 for out-of-range index).
module aes_rcon_rom
    import aes_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic [CNT_W-1:0] rnd_num,
    output logic [7:0]       rcon
);

    always_comb begin
        rcon = rcon_of(32'(rnd_num));
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption sequencer: owns state/round-key regs and loops an external round datapath NR times.
// Latency: ciphertext valid NR+1 cycles after the accept cycle (accept cycle counted); one block in flight.
// Backpressure: in_ready low while busy; out_ready low holds DONE with out_ct/out_valid stable.
// Ports: clk, rst (sync, active-high), bus (slave: in_valid/in_ready/in_pt/in_key/out_valid/out_ready/out_ct),
//        rnd_state_o/rnd_key_o/rnd_num_o/rnd_final_o/rcon_o to the datapath, rnd_state_i/rnd_key_i back from it.
// Option: AES_CTRL_PERF_EN adds blk_cnt_o, a wrapping count of completed output handshakes.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = NR_128,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    aes_round_ctrl_if.slave   bus,
    output blk_t              rnd_state_o,
    output blk_t              rnd_key_o,
    output logic [CNT_W-1:0]  rnd_num_o,
    output logic              rnd_final_o,
    output logic [7:0]        rcon_o,
    input  blk_t              rnd_state_i,
    input  blk_t              rnd_key_i
`ifdef AES_CTRL_PERF_EN
    ,
    output logic [31:0]       blk_cnt_o
`endif
);

    localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(NR);

    ctrl_state_e      fsm_q, fsm_d;
    blk_t             state_q, state_d;
    blk_t             key_q, key_d;
    logic [CNT_W-1:0] rnd_q, rnd_d;
    logic [7:0]       rcon_raw;

    aes_rcon_rom #(.CNT_W(CNT_W)) u_rcon_rom (
        .rnd_num (rnd_q),
        .rcon    (rcon_raw)
    );

    // State register (FSM plus the datapath registers it sequences).
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
        end
    end

    // Next-state logic. The counter only advances below LAST_RND, so it cannot wrap.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        case (fsm_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Initial AddRoundKey with K(0) is folded into the load.
                    state_d = bus.in_pt ^ bus.in_key;
                    key_d   = bus.in_key;
                    rnd_d   = CNT_W'(1);
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                state_d = rnd_state_i;
                key_d   = rnd_key_i;
                if (rnd_q == LAST_RND) begin
                    fsm_d = DONE;
                end else begin
                    rnd_d = rnd_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        bus.in_ready  = (fsm_q == IDLE);
        bus.out_valid = (fsm_q == DONE);
        bus.out_ct    = state_q;
        rnd_state_o   = state_q;
        rnd_key_o     = key_q;
        rnd_num_o     = rnd_q;
        rnd_final_o   = (fsm_q == ROUND) && (rnd_q == LAST_RND);
        rcon_o        = (fsm_q == ROUND) ? rcon_raw : 8'h00;
    end

`ifdef AES_CTRL_PERF_EN
    logic [31:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if ((fsm_q == DONE) && bus.out_ready) begin
            blk_cnt_d = blk_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign blk_cnt_o = blk_cnt_q;
`endif

endmodule
